// File: rtl/ob_table_cnt_cpa.sv
// ob_table_cnt_cpa: iterative carry-propagate resolver for the table count path.
// Accepts one redundant sum/carry pair and resolves it CHUNK bits per cycle
// into a binary count with a separate carry-out flag.
module ob_table_cnt_cpa #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_c,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_sum,
  output logic         out_ovf,
  input  logic         out_rdy,
  output logic         busy
);

  localparam int NCHUNK = W / CHUNK;
  // A single-chunk configuration still needs a one-bit index register.
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    s_q;
  logic [W-1:0]    c_q;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [CHUNK:0]  chunk_sum;

  // Handshake flags depend on state only, so no input reaches them combinationally.
  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign busy    = (state != IDLE);

  // Add the currently selected chunk of the captured pair plus the running carry.
  always_comb begin
    chunk_sum = {1'b0, s_q[int'(idx) * CHUNK +: CHUNK]}
              + {1'b0, c_q[int'(idx) * CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
  end

  // Control FSM and datapath registers: capture, chunk-serial add, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            s_q   <= in_s;
            c_q   <= in_c;
            idx   <= '0;
            carry <= 1'b0;
            state <= ADD;
          end
        end
        ADD: begin
          // Unresolved chunks keep their old contents until their turn comes.
          out_sum[int'(idx) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          if (idx == LAST) begin
            // The final carry leaves only through out_ovf, never back into chunk 0.
            out_ovf <= chunk_sum[CHUNK];
            idx     <= '0;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ob_table_cnt_cpa.sv
// Bench for ob_table_cnt_cpa: instance 0 uses CHUNK=8 (4 add cycles),
// instance 1 uses CHUNK=W (single add cycle). Expected results are pushed to
// a per-instance queue on each accept and compared when the result is taken.
module tb_ob_table_cnt_cpa;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld  [2];
  logic [31:0] in_s    [2];
  logic [31:0] in_c    [2];
  logic        in_rdy  [2];
  logic        out_vld [2];
  logic [31:0] out_sum [2];
  logic        out_ovf [2];
  logic        out_rdy [2];
  logic        busy    [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [32:0] sbq [2][$];
  int acc_cnt  [2] = '{0, 0};
  int ret_cnt  [2] = '{0, 0};
  int last_acc [2] = '{0, 0};
  int prev_acc [2] = '{0, 0};
  int rise_cyc [2] = '{0, 0};
  logic prev_vld [2] = '{1'b0, 1'b0};
  int nch [2] = '{4, 1};

  always #5 clk = ~clk;

  ob_table_cnt_cpa #(.W(W), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst),
    .in_vld(in_vld[0]), .in_s(in_s[0]), .in_c(in_c[0]), .in_rdy(in_rdy[0]),
    .out_vld(out_vld[0]), .out_sum(out_sum[0]), .out_ovf(out_ovf[0]),
    .out_rdy(out_rdy[0]), .busy(busy[0])
  );

  ob_table_cnt_cpa #(.W(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst(rst),
    .in_vld(in_vld[1]), .in_s(in_s[1]), .in_c(in_c[1]), .in_rdy(in_rdy[1]),
    .out_vld(out_vld[1]), .out_sum(out_sum[1]), .out_ovf(out_ovf[1]),
    .out_rdy(out_rdy[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge: note handshakes before the edge, update scoreboard after it.
  task automatic tick();
    logic        acc  [2];
    logic        ret  [2];
    logic [31:0] osum [2];
    logic        oovf [2];
    logic [32:0] e    [2];
    logic [32:0] exp_r;
    for (int i = 0; i < 2; i++) begin
      acc[i]  = in_vld[i] && in_rdy[i] && !rst;
      ret[i]  = out_vld[i] && out_rdy[i] && !rst;
      osum[i] = out_sum[i];
      oovf[i] = out_ovf[i];
      e[i]    = {1'b0, in_s[i]} + {1'b0, in_c[i]};
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sbq[i].delete();
      end else begin
        if (ret[i]) begin
          chk($sformatf("sb_has_entry[%0d]", i), 64'(sbq[i].size() != 0), 64'd1);
          if (sbq[i].size() != 0) begin
            exp_r = sbq[i].pop_front();
            chk($sformatf("out_sum[%0d]", i), 64'(osum[i]), 64'(exp_r[31:0]));
            chk($sformatf("out_ovf[%0d]", i), 64'(oovf[i]), 64'(exp_r[32]));
          end
          ret_cnt[i]++;
        end
        if (acc[i]) begin
          sbq[i].push_back(e[i]);
          prev_acc[i] = last_acc[i];
          last_acc[i] = cyc;
          acc_cnt[i]++;
        end
      end
      if (out_vld[i] && !prev_vld[i]) rise_cyc[i] = cyc;
      prev_vld[i] = out_vld[i];
    end
  endtask

  task automatic send(input int i, input logic [31:0] s, input logic [31:0] c);
    int n = acc_cnt[i];
    in_s[i] = s;
    in_c[i] = c;
    in_vld[i] = 1'b1;
    for (int k = 0; k < 50 && acc_cnt[i] == n; k++) tick();
    in_vld[i] = 1'b0;
    chk($sformatf("accept_timeout[%0d]", i), 64'(acc_cnt[i] != n), 64'd1);
  endtask

  task automatic recv(input int i, input int target);
    for (int k = 0; k < 100 && ret_cnt[i] < target; k++) tick();
    chk($sformatf("result_timeout[%0d]", i), 64'(ret_cnt[i] >= target), 64'd1);
  endtask

  task automatic wait_vld(input int i);
    for (int k = 0; k < 50 && !out_vld[i]; k++) tick();
    chk($sformatf("vld_timeout[%0d]", i), 64'(out_vld[i]), 64'd1);
  endtask

  // Two pairs with in_vld held high throughout; checks spacing and latency.
  task automatic pair2(input int i, input logic [31:0] s1, input logic [31:0] c1,
                       input logic [31:0] s2, input logic [31:0] c2, input int spacing);
    int n = acc_cnt[i];
    int r = ret_cnt[i];
    in_s[i] = s1;
    in_c[i] = c1;
    in_vld[i] = 1'b1;
    for (int k = 0; k < 100 && acc_cnt[i] < n + 2; k++) begin
      tick();
      if (acc_cnt[i] == n + 1) begin
        in_s[i] = s2;
        in_c[i] = c2;
      end
    end
    in_vld[i] = 1'b0;
    chk($sformatf("pair_accepts[%0d]", i), 64'(acc_cnt[i] - n), 64'd2);
    chk($sformatf("accept_spacing[%0d]", i), 64'(last_acc[i] - prev_acc[i]), 64'(spacing));
    recv(i, r + 2);
    chk($sformatf("latency[%0d]", i), 64'(rise_cyc[i] - last_acc[i]), 64'(nch[i]));
  endtask

  initial begin
    int r0;
    // Reset with in_vld high: nothing may be accepted.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_vld[i]  = 1'b1;
      in_s[i]    = 32'hDEAD_BEEF;
      in_c[i]    = 32'h0BAD_F00D;
      out_rdy[i] = 1'b1;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_vld[%0d]", i), 64'(out_vld[i]), 64'd0);
      chk($sformatf("rst_out_sum[%0d]", i), 64'(out_sum[i]), 64'd0);
      chk($sformatf("rst_out_ovf[%0d]", i), 64'(out_ovf[i]), 64'd0);
      chk($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("rst_in_rdy[%0d]", i), 64'(in_rdy[i]), 64'd1);
      in_vld[i] = 1'b0;
    end
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy[0]), 64'd0);

    // Carry across one chunk boundary; latency of NCHUNK edges.
    send(0, 32'h0000_00FF, 32'h0000_0001);
    wait_vld(0);
    chk("latency_4", 64'(rise_cyc[0] - last_acc[0]), 64'd4);
    chk("busy_done", 64'(busy[0]), 64'd1);
    recv(0, 1);

    // Carry ripples through all chunks into out_ovf.
    send(0, 32'hFFFF_FFFF, 32'h0000_0001);
    recv(0, 2);

    // Backpressure: result held, second pair refused while DONE.
    out_rdy[0] = 1'b0;
    send(0, 32'h1234_5678, 32'h1111_1111);
    wait_vld(0);
    in_s[0] = 32'h0000_0005;
    in_c[0] = 32'h0000_0006;
    in_vld[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_out_vld", 64'(out_vld[0]), 64'd1);
      chk("hold_out_sum", 64'(out_sum[0]), 64'h2345_6789);
      chk("hold_in_rdy", 64'(in_rdy[0]), 64'd0);
    end
    chk("hold_no_accept", 64'(acc_cnt[0]), 64'd3);
    out_rdy[0] = 1'b1;
    for (int k = 0; k < 20 && acc_cnt[0] < 4; k++) tick();
    in_vld[0] = 1'b0;
    chk("post_hold_accept", 64'(acc_cnt[0]), 64'd4);
    recv(0, 4);

    // Reset in the middle of ADD abandons the transaction.
    send(0, 32'h0000_AAAA, 32'h0000_5555);
    tick();
    tick();
    chk("mid_add_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_vld", 64'(out_vld[0]), 64'd0);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_in_rdy", 64'(in_rdy[0]), 64'd1);
    chk("abort_out_sum", 64'(out_sum[0]), 64'd0);
    r0 = ret_cnt[0];
    send(0, 32'h0000_0010, 32'h0000_0020);
    recv(0, r0 + 1);

    // Back-to-back pairs with in_vld held high, both configurations.
    pair2(0, 32'h8000_0001, 32'h8000_0001, 32'h00FF_FF00, 32'h0000_0100, 6);
    pair2(1, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0007, 32'h0000_0008, 3);

    chk("sb_drained0", 64'(sbq[0].size()), 64'd0);
    chk("sb_drained1", 64'(sbq[1].size()), 64'd0);
    chk("results0", 64'(ret_cnt[0]), 64'd7);
    chk("results1", 64'(ret_cnt[1]), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ob_table_cnt_cpa.md
Name: ob_table_cnt_cpa

Overview:
Carry-propagate resolver for the table count path. It accepts one redundant sum/carry word pair, as produced by the count CSA reduction network, and resolves it into a single binary count. The addition is done iteratively, CHUNK bits per cycle, to keep the carry chain off the critical path. It sits between the CSA tree output and the consumers of the table count. Valid/ready handshakes are used on both sides.

Parameters:
W, 32, width of the s/c input words and of the resolved sum; must be a multiple of CHUNK.
CHUNK, 8, bits resolved per cycle; NCHUNK = W/CHUNK; CHUNK == W gives a single ADD cycle.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_vld  in  1  s/c pair valid
in_s  in  W  save (sum) word
in_c  in  W  carry word, already weight-aligned (no shift applied here)
in_rdy  out  1  block can accept a pair
out_vld  out  1  resolved result valid
out_sum  out  W  (in_s + in_c) mod 2^W
out_ovf  out  1  carry out of bit W-1
out_rdy  in  1  consumer accepts result
busy  out  1  state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high, and overrides all other activity on the same edge.
- Reset values:
  - state = IDLE
  - in_rdy = 1 (combinational from state)
  - out_vld = 0, out_sum = 0, out_ovf = 0, busy = 0
  - internal chunk index = 0, carry register = 0
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_rdy = 1.
  - On in_vld & in_rdy: register in_s and in_c, set idx = 0, carry = 0, go to ADD.
  - in_s and in_c are sampled only on the handshake edge; later changes on them are ignored.
- ADD, one edge per chunk:
  - {carry', out_sum[idx*CHUNK +: CHUNK]} = s_q[chunk idx] + c_q[chunk idx] + carry.
  - idx increments each edge.
  - On the edge where idx == NCHUNK-1: out_ovf = carry', go to DONE.
  - in_rdy = 0.
- DONE:
  - out_vld = 1; out_sum and out_ovf are held stable while out_rdy = 0.
  - On out_vld & out_rdy: go to IDLE.
  - in_rdy = 0; in_vld is ignored.
- out_sum:
  - Chunks not yet resolved are undefined until DONE, but are implemented as retaining their previous value.
  - out_sum is meaningful only while out_vld = 1.
- Latency:
  - Pair accepted on edge k; out_vld rises after edge k+NCHUNK.
  - Minimum accept-to-accept spacing is NCHUNK+2 edges (out_rdy tied high).
- Arithmetic:
  - Unsigned, modulo 2^W.
  - Carry never wraps into chunk 0; it is exported only via out_ovf.
- Reset mid-ADD or mid-DONE: the transaction is abandoned with no output, and the block returns to IDLE on the next cycle.
- in_vld asserted during reset: not accepted.
- No combinational path from any input to any output except in_rdy and out_vld, which depend on state only.

Test Plan:
1. Assert rst for 2 cycles with in_vld = 1 -> out_vld = 0, out_sum = 0, out_ovf = 0, busy = 0, in_rdy = 1; no pair is accepted.
2. W=32, CHUNK=8: in_s = 0x0000_00FF, in_c = 0x0000_0001 -> out_sum = 0x0000_0100, out_ovf = 0, out_vld high exactly 4 edges after the accept edge.
3. in_s = 0xFFFF_FFFF, in_c = 0x0000_0001 -> out_sum = 0x0000_0000, out_ovf = 1 (carry ripples through all 4 chunks).
4. in_s = 0x1234_5678, in_c = 0x1111_1111, out_rdy held low 5 cycles -> out_sum = 0x2345_6789 stable, out_vld = 1, in_rdy = 0; a second in_vld during this time is not accepted until after out_rdy is asserted.
5. Assert rst while idx = 2 during ADD -> IDLE and out_vld = 0 next cycle; a subsequent pair 0x10 + 0x20 resolves to 0x30.
6. in_vld held high with two pairs and out_rdy = 1 -> both results correct and in order; accept edges are 6 apart (NCHUNK+2); repeat with CHUNK = W -> spacing of 3 and out_vld 1 edge after accept.
